// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle RV32I control FSM placed directly upstream of the
//               ALU. Sequences IF/ID/EX/MEM/WB, decodes the instruction
//               register and drives the ALU opcode/operand select. Consumes
//               the ALU zero flag for BEQ and waits on a memory ready
//               handshake during fetch and data access.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         synchronous active-high reset
//   instr      in   32        instruction register contents
//   zero       in   1         ALU zero flag (used in EX of BEQ only)
//   mem_ready  in   1         completes the current mem_req cycle
//   mem_req    out  1         memory access request (fetch or data)
//   mem_we     out  1         data write (SW in MEM)
//   ir_write   out  1         load instruction register
//   pc_write   out  1         update PC this cycle
//   pc_src     out  1         0: PC+4, 1: branch target
//   alu_src    out  1         0: rs2, 1: immediate
//   alu_op     out  ALU_OP_W  ALU opcode
//   imm_sel    out  2         00 I, 01 S, 10 B
//   reg_write  out  1         register file write enable
//   mem_to_reg out  1         WB source: 1 memory, 0 ALU
//   illegal    out  1         sticky illegal-instruction flag
//   state      out  STATE_W   IF 0, ID 1, EX 2, MEM 3, WB 4, HALT 5
// Configuration macro
//   ILLEGAL_TRAP_EN : illegal instruction halts the FSM until rst. When
//                     undefined, an illegal instruction retires as a NOP.
// ============================================================================
module multicycle_control #(
    parameter int ALU_OP_W = 4,
    parameter int STATE_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          imm_sel,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [ALU_OP_W-1:0] c_ALU_AND = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] c_ALU_OR  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] c_ALU_ADD = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] c_ALU_SLT = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] c_ALU_XOR = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] c_ALU_SRL = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] c_ALU_SLL = ALU_OP_W'(4'b1001);
    localparam logic [ALU_OP_W-1:0] c_ALU_SRA = ALU_OP_W'(4'b1010);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    state_t r_state;
    state_t w_next;

    // ------------------------------------------------------------------
    // Instruction decode (purely combinational from instr)
    // ------------------------------------------------------------------
    logic [6:0]          w_opcode;
    logic [2:0]          w_f3;
    logic                w_f7b;
    logic                w_is_r;
    logic                w_is_i;
    logic                w_is_lw;
    logic                w_is_sw;
    logic                w_is_beq;
    logic                w_legal;
    logic                w_dec_alu_src;
    logic [ALU_OP_W-1:0] w_dec_alu_op;
    logic [1:0]          w_dec_imm_sel;
    logic                w_unused;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7b    = instr[30];

    // Register/immediate fields are consumed by the datapath, not here.
    assign w_unused = &{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        // f3 011 (SLTU/SLTIU) is outside the supported subset for both
        // ALU formats, so it is folded into the illegal class here.
        w_is_r   = (w_opcode == c_OP_R)   && (w_f3 != 3'b011);
        w_is_i   = (w_opcode == c_OP_I)   && (w_f3 != 3'b011);
        w_is_lw  = (w_opcode == c_OP_LW)  && (w_f3 == 3'b010);
        w_is_sw  = (w_opcode == c_OP_SW)  && (w_f3 == 3'b010);
        w_is_beq = (w_opcode == c_OP_BEQ) && (w_f3 == 3'b000);
        w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq;

        w_dec_alu_src = w_is_i | w_is_lw | w_is_sw;

        w_dec_imm_sel = 2'b00;
        if (w_is_sw) begin
            w_dec_imm_sel = 2'b01;
        end else if (w_is_beq) begin
            w_dec_imm_sel = 2'b10;
        end

        w_dec_alu_op = c_ALU_ADD;
        if (w_is_lw || w_is_sw) begin
            w_dec_alu_op = c_ALU_ADD;
        end else if (w_is_beq) begin
            w_dec_alu_op = c_ALU_SUB;
        end else begin
            case (w_f3)
                // Only the register form uses f7b to select SUB; ADDI has
                // immediate bits in that position.
                3'b000:  w_dec_alu_op = (w_is_r && w_f7b) ? c_ALU_SUB : c_ALU_ADD;
                3'b001:  w_dec_alu_op = c_ALU_SLL;
                3'b010:  w_dec_alu_op = c_ALU_SLT;
                3'b100:  w_dec_alu_op = c_ALU_XOR;
                3'b101:  w_dec_alu_op = w_f7b ? c_ALU_SRA : c_ALU_SRL;
                3'b110:  w_dec_alu_op = c_ALU_OR;
                3'b111:  w_dec_alu_op = c_ALU_AND;
                default: w_dec_alu_op = c_ALU_ADD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = c_ALU_ADD;
        imm_sel    = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        case (r_state)
            S_IF: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) begin
                    w_next = S_ID;
                end
            end

            S_ID: begin
                alu_op  = w_dec_alu_op;
                alu_src = w_dec_alu_src;
                imm_sel = w_dec_imm_sel;
                if (w_legal) begin
                    w_next = S_EX;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    // Retire as a NOP: advance PC and refetch.
                    pc_write = 1'b1;
                    w_next   = S_IF;
`endif
                end
            end

            S_EX: begin
                alu_op  = w_dec_alu_op;
                alu_src = w_dec_alu_src;
                imm_sel = w_dec_imm_sel;
                if (w_is_beq) begin
                    pc_write = 1'b1;
                    pc_src   = zero;
                    w_next   = S_IF;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_sw;
                alu_op  = c_ALU_ADD;
                alu_src = 1'b1;
                imm_sel = w_dec_imm_sel;
                if (mem_ready) begin
                    if (w_is_sw) begin
                        pc_write = 1'b1;
                        w_next   = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end

            S_WB: begin
                // ALU controls stay at their EX values so the result
                // being written back remains stable.
                reg_write  = 1'b1;
                mem_to_reg = w_is_lw;
                pc_write   = 1'b1;
                alu_op     = w_dec_alu_op;
                alu_src    = w_dec_alu_src;
                imm_sel    = w_dec_imm_sel;
                w_next     = S_IF;
            end

            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                w_next = S_HALT;
`else
                w_next = S_IF;
`endif
            end

            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Illegal flag
    // ------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    // Rises together with entry into HALT; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_next == S_HALT) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign state = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A per-instruction
//               reference model expands each instruction into its expected
//               cycle-by-cycle trace of state and control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [31:0] instr     = 32'h0;
    logic        zero      = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
    logic [3:0]  alu_op;
    logic [1:0]  imm_sel;
    logic        reg_write, mem_to_reg, illegal;
    logic [2:0]  state;

    multicycle_control #(.ALU_OP_W(4), .STATE_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Observed vector: state | mem_req mem_we ir_write pc_write pc_src alu_src
    //                  | alu_op | imm_sel | reg_write mem_to_reg illegal
    logic [17:0] obs;
    assign obs = {state, mem_req, mem_we, ir_write, pc_write, pc_src, alu_src,
                  alu_op, imm_sel, reg_write, mem_to_reg, illegal};

    localparam logic [17:0] M_ALL   = 18'h3FFFF;
    localparam logic [17:0] M_NOALU = 18'h3FFFF & ~18'h003F8; // hide alu_src/alu_op/imm_sel
    localparam logic [17:0] M_NOIMM = 18'h3FFFF & ~18'h00018; // hide imm_sel

    localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BEQ = 4, CL_ILL = 5;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ins;
        logic        mr;
        logic        z;
        logic [17:0] val;
        logic [17:0] msk;
    } step_t;

    step_t q[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic asrc, input logic [3:0] aop, input logic [1:0] isel,
                                       input logic rw, input logic m2r, input logic ill);
        return {st, mreq, mwe, irw, pcw, pcs, asrc, aop, isel, rw, m2r, ill};
    endfunction

    function automatic int cls_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33:   return (f3 == 3'b011) ? CL_ILL : CL_R;
            7'h13:   return (f3 == 3'b011) ? CL_ILL : CL_I;
            7'h03:   return (f3 == 3'b010) ? CL_LW  : CL_ILL;
            7'h23:   return (f3 == 3'b010) ? CL_SW  : CL_ILL;
            7'h63:   return (f3 == 3'b000) ? CL_BEQ : CL_ILL;
            default: return CL_ILL;
        endcase
    endfunction

    function automatic logic [3:0] exp_op(input logic [31:0] ins);
        int c;
        c = cls_of(ins);
        if (c == CL_LW || c == CL_SW) return 4'b0010;
        if (c == CL_BEQ) return 4'b0110;
        case (ins[14:12])
            3'd0:    return (c == CL_R && ins[30]) ? 4'b0110 : 4'b0010;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0100;
            3'd4:    return 4'b0101;
            3'd5:    return ins[30] ? 4'b1010 : 4'b1000;
            3'd6:    return 4'b0001;
            3'd7:    return 4'b0000;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic void push(input logic [31:0] ins, input logic mr, input logic z,
                                 input logic [17:0] v, input logic [17:0] m);
        step_t s;
        s.ins = ins; s.mr = mr; s.z = z; s.val = v; s.msk = m;
        q.push_back(s);
    endfunction

    // Expand one instruction into its expected per-cycle trace.
    function automatic void build(input logic [31:0] ins, input int if_wait, input int mem_wait,
                                  input logic z, input int halt_n);
        int          c;
        logic [3:0]  op;
        logic        asrc, is_sw, is_lw, is_beq;
        logic [1:0]  isel;
        logic [17:0] emsk;
        c      = cls_of(ins);
        op     = exp_op(ins);
        is_sw  = (c == CL_SW);
        is_lw  = (c == CL_LW);
        is_beq = (c == CL_BEQ);
        asrc   = (c == CL_I) || is_lw || is_sw;
        isel   = is_sw ? 2'b01 : (is_beq ? 2'b10 : 2'b00);
        emsk   = (c == CL_R) ? M_NOIMM : M_ALL;

        for (int k = 0; k < if_wait; k++)
            push(ins, 1'b0, rb(), mk(3'd0,1,0,0,0,0,0,4'b0010,2'b00,0,0,0), M_ALL);
        push(ins, 1'b1, rb(), mk(3'd0,1,0,1,0,0,0,4'b0010,2'b00,0,0,0), M_ALL);

        if (c == CL_ILL) begin
`ifdef ILLEGAL_TRAP_EN
            push(ins, rb(), rb(), mk(3'd1,0,0,0,0,0,0,4'b0,2'b0,0,0,0), M_NOALU);
            for (int k = 0; k < halt_n; k++)
                push(ins, rb(), rb(), mk(3'd5,0,0,0,0,0,0,4'b0,2'b0,0,0,1), M_NOALU);
`else
            if (halt_n < 0) return;
            push(ins, rb(), rb(), mk(3'd1,0,0,0,1,0,0,4'b0,2'b0,0,0,0), M_NOALU);
`endif
            return;
        end

        push(ins, rb(), rb(), mk(3'd1,0,0,0,0,0,0,4'b0,2'b0,0,0,0), M_NOALU);
        push(ins, rb(), z, mk(3'd2,0,0,0,is_beq,is_beq & z,asrc,op,isel,0,0,0), emsk);
        if (is_beq) return;

        if (is_lw || is_sw) begin
            for (int k = 0; k < mem_wait; k++)
                push(ins, 1'b0, rb(), mk(3'd3,1,is_sw,0,0,0,1,4'b0010,2'b0,0,0,0), M_NOIMM);
            push(ins, 1'b1, rb(), mk(3'd3,1,is_sw,0,is_sw,0,1,4'b0010,2'b0,0,0,0), M_NOIMM);
            if (is_sw) return;
        end

        push(ins, rb(), rb(), mk(3'd4,0,0,0,1,0,asrc,op,2'b0,1,is_lw,0), M_NOIMM);
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0: begin w[6:0] = 7'h33; w[31:25] = {1'b0, rb(), 5'b0}; end
            1: w[6:0] = 7'h13;
            2: begin w[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
            3: begin w[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
            4: begin w[6:0] = 7'h63; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000; end
            default: ;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (obs !== mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0)) begin
            bad++;
            $display("FAIL reset_if: got %h want %h", obs, mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0));
        end
        mem_ready = 1'b1;
        #1;
        total++;
        if (obs !== mk(3'd0,1,0,1,0,0,0,4'b0010,2'b0,0,0,0)) begin
            bad++;
            $display("FAIL reset_irw: got %h want %h", obs, mk(3'd0,1,0,1,0,0,0,4'b0010,2'b0,0,0,0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_alu_ops();
        build(32'h002081B3, 0, 0, 1'b0, 0);   // add x3,x1,x2
        build(32'h402081B3, 1, 0, 1'b0, 0);   // sub
        build(32'h4040D093, 2, 0, 1'b0, 0);   // srai x1,x1,4
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL alu_ops step %0d: got %h want %h", i, obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_lw_wait();
        build(32'h0080A283, 2, 3, 1'b0, 0);   // lw x5,8(x1), MEM held 4 cycles
        build(32'h0020A423, 0, 2, 1'b0, 0);   // sw x2,8(x1)
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL mem_wait step %0d: got %h want %h", i, obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_beq();
        build(32'h00208463, 0, 0, 1'b1, 0);   // taken
        build(32'h00208463, 0, 0, 1'b0, 0);   // not taken
        build(32'h002081B3, 0, 0, 1'b0, 0);   // proves return to IF
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL beq step %0d: got %h want %h", i, obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    task automatic test_sw_reset();
        build(32'h0020A423, 0, 3, 1'b0, 0);
        // Steps 0..3 are IF, ID, EX and the first MEM cycle.
        for (int i = 0; i < 4; i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            if (i == 3) rst = 1'b1;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL sw_reset step %0d: got %h want %h", i, obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0)) begin
            bad++;
            $display("FAIL sw_reset_after: got %h want %h", obs, mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0));
        end
        @(posedge clk); #1;
        q.delete();
    endtask

    task automatic test_illegal();
        build(32'h0000007F, 1, 0, 1'b0, 10);
`ifndef ILLEGAL_TRAP_EN
        build(32'h002081B3, 0, 0, 1'b0, 0);
`endif
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL illegal step %0d: got %h want %h", i, obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        q.delete();
`ifdef ILLEGAL_TRAP_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0)) begin
            bad++;
            $display("FAIL halt_clear: got %h want %h", obs, mk(3'd0,1,0,0,0,0,0,4'b0010,2'b0,0,0,0));
        end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int n = 0; n < 200; n++) begin
            w = gen();
`ifdef ILLEGAL_TRAP_EN
            while (cls_of(w) == CL_ILL) w = gen();
`endif
            build(w, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 0);
        end
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].ins; mem_ready = q[i].mr; zero = q[i].z;
            @(negedge clk);
            total++;
            if ((obs & q[i].msk) !== (q[i].val & q[i].msk)) begin
                bad++;
                $display("FAIL random step %0d instr %h: got %h want %h", i, q[i].ins,
                         obs & q[i].msk, q[i].val & q[i].msk);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_lw_wait();
        test_beq();
        test_sw_reset();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
